// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating direction counters.
//
// The fetch-side lookup is combinational from the registered table. A resolved
// conditional branch trains the counter and target on the clock edge. Running
// counts of resolved branches and correct predictions are also kept here.
//
// Ports:
//   CLK, RST      clock (rising edge), asynchronous active-high reset
//   en            run enable; table and statistics change only when en=1
//   PC            fetch address to look up
//   pred_taken    predicted taken for PC
//   pred_target   predicted next PC (stored target, or PC+4)
//   hit           PC matches a valid entry
//   upd_valid     a conditional branch resolved this cycle
//   upd_pc        address of the resolved branch
//   upd_taken     actual outcome
//   upd_target    actual taken target
//   branch_cnt    resolved branch count (wraps)
//   correct_cnt   correct prediction count (wraps)
module branch_predictor #(
    parameter int IDX_BITS = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        en,
    input  logic [31:0] PC,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        hit,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [15:0] branch_cnt,
    output logic [15:0] correct_cnt
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 32 - IDX_BITS - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       ctr;
    } entry_t;

    entry_t tbl [ENTRIES];

    // Word-aligned addresses: the low two bits never take part.
    logic unused_low_bits;
    assign unused_low_bits = ^{PC[1:0], upd_pc[1:0]};

    // Fetch-side lookup.
    logic [IDX_BITS-1:0] idx;
    logic [TAG_W-1:0]    pc_tag;
    entry_t              lk;

    assign idx         = PC[IDX_BITS+1:2];
    assign pc_tag      = PC[31:IDX_BITS+2];
    assign lk          = tbl[idx];
    assign hit         = lk.valid && (lk.tag == pc_tag);
    assign pred_taken  = hit && lk.ctr[1];
    assign pred_target = pred_taken ? lk.target : PC + 32'd4;

    // Update-side lookup, using the pre-edge state.
    logic [IDX_BITS-1:0] u_idx;
    entry_t              ue;
    logic                u_hit;
    logic                u_pred;
    logic                u_correct;

    assign u_idx     = upd_pc[IDX_BITS+1:2];
    assign ue        = tbl[u_idx];
    assign u_hit     = ue.valid && (ue.tag == upd_pc[31:IDX_BITS+2]);
    assign u_pred    = u_hit && ue.ctr[1];
    // A taken prediction only counts if it also pointed at the right target.
    assign u_correct = (u_pred == upd_taken) && (!upd_taken || ue.target == upd_target);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i].valid  <= 1'b0;
                tbl[i].tag    <= '0;
                tbl[i].target <= '0;
                tbl[i].ctr    <= 2'b01;
            end
            branch_cnt  <= '0;
            correct_cnt <= '0;
        end else if (en && upd_valid) begin
            branch_cnt <= branch_cnt + 16'd1;
            if (u_correct)
                correct_cnt <= correct_cnt + 16'd1;
            if (u_hit) begin
                if (upd_taken) begin
                    tbl[u_idx].ctr    <= (ue.ctr == 2'b11) ? 2'b11 : ue.ctr + 2'd1;
                    tbl[u_idx].target <= upd_target;
                end else begin
                    tbl[u_idx].ctr <= (ue.ctr == 2'b00) ? 2'b00 : ue.ctr - 2'd1;
                end
            end else if (upd_taken) begin
                // Taken miss evicts whatever lives at this index; not-taken misses never do.
                tbl[u_idx].valid  <= 1'b1;
                tbl[u_idx].tag    <= upd_pc[31:IDX_BITS+2];
                tbl[u_idx].target <= upd_target;
                tbl[u_idx].ctr    <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    logic        CLK = 1'b0;
    logic        RST;
    logic        en;
    logic [31:0] PC;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        hit;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [15:0] branch_cnt;
    logic [15:0] correct_cnt;

    int errors = 0;
    int checks = 0;

    branch_predictor #(.IDX_BITS(3)) dut (
        .CLK(CLK), .RST(RST), .en(en), .PC(PC),
        .pred_taken(pred_taken), .pred_target(pred_target), .hit(hit),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .branch_cnt(branch_cnt), .correct_cnt(correct_cnt)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model (8 entries) ----------------
    bit          m_valid [8];
    int unsigned m_tag   [8];
    logic [31:0] m_tgt   [8];
    int          m_ctr   [8];   // 0..3, predicts taken when >= 2
    int          m_bc;
    int          m_cc;

    function automatic int m_idx(input logic [31:0] a);
        return int'((a / 4) % 8);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == a / 32);
    endfunction

    function automatic bit m_pt(input logic [31:0] a);
        return m_hit(a) && (m_ctr[m_idx(a)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] a);
        logic [31:0] nxt;
        nxt = a + 32'd4;
        return m_pt(a) ? m_tgt[m_idx(a)] : nxt;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 8; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
            end
            m_bc = 0; m_cc = 0;
        end else if (en && upd_valid) begin
            int  i;
            bit  h, p, ok;
            i  = m_idx(upd_pc);
            h  = m_hit(upd_pc);
            p  = m_pt(upd_pc);
            ok = (p == upd_taken) && (!upd_taken || m_tgt[i] == upd_target);
            m_bc = (m_bc + 1) % 65536;
            if (ok) m_cc = (m_cc + 1) % 65536;
            if (h) begin
                if (upd_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = upd_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (upd_taken) begin
                m_valid[i] = 1; m_tag[i] = upd_pc / 32; m_tgt[i] = upd_target; m_ctr[i] = 2;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model comparison every cycle, away from the active edge.
    always @(negedge CLK) begin
        chk("cmp_hit",         {31'd0, hit},        {31'd0, m_hit(PC)});
        chk("cmp_pred_taken",  {31'd0, pred_taken}, {31'd0, m_pt(PC)});
        chk("cmp_pred_target", pred_target,         m_ptgt(PC));
        chk("cmp_branch_cnt",  {16'd0, branch_cnt},  m_bc[31:0]);
        chk("cmp_correct_cnt", {16'd0, correct_cnt}, m_cc[31:0]);
    end

    // Inputs change 2 time units after a rising edge.
    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tg;
        @(posedge CLK); #2;
        upd_valid = 0;
    endtask

    task automatic look(input string name, input logic [31:0] pc,
                        input logic eh, input logic ep, input logic [31:0] et);
        PC = pc; #1;
        chk({name, "_hit"}, {31'd0, hit},        {31'd0, eh});
        chk({name, "_pt"},  {31'd0, pred_taken}, {31'd0, ep});
        chk({name, "_tgt"}, pred_target,         et);
    endtask

    task automatic cnts(input string name, input int bc, input int cc);
        chk({name, "_bc"}, {16'd0, branch_cnt},  bc[31:0]);
        chk({name, "_cc"}, {16'd0, correct_cnt}, cc[31:0]);
    endtask

    logic [31:0] pool [6];

    initial begin
        RST = 1; en = 0; PC = 32'h10;
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
        #1;
        look("rst", 32'h10, 0, 0, 32'h14);
        cnts("rst", 0, 0);
        // Update asserted during reset is ignored.
        en = 1; upd_valid = 1; upd_pc = 32'h40; upd_taken = 1; upd_target = 32'h100;
        repeat (2) @(posedge CLK);
        #2; upd_valid = 0; RST = 0;
        look("rst_ign", 32'h40, 0, 0, 32'h44);

        // Allocation and training.
        upd(32'h40, 1, 32'h100);
        look("alloc", 32'h40, 1, 1, 32'h100);   cnts("alloc", 1, 0);
        upd(32'h40, 1, 32'h100);
        look("train", 32'h40, 1, 1, 32'h100);   cnts("train", 2, 1);
        upd(32'h40, 0, 32'h0);
        look("hyst1", 32'h40, 1, 1, 32'h100);   cnts("hyst1", 3, 1);
        upd(32'h40, 0, 32'h0);
        look("hyst2", 32'h40, 1, 0, 32'h44);    cnts("hyst2", 4, 1);
        upd(32'h40, 0, 32'h0);
        upd(32'h40, 0, 32'h0);
        look("sat0", 32'h40, 1, 0, 32'h44);     cnts("sat0", 6, 3);
        upd(32'h40, 1, 32'h100);                // 00 -> 01, still not-taken
        look("sat0b", 32'h40, 1, 0, 32'h44);    cnts("sat0b", 7, 3);

        // Not-taken misses: empty entry, and an occupied index (no eviction).
        upd(32'h84, 0, 32'h300);
        look("ntmiss", 32'h84, 0, 0, 32'h88);   cnts("ntmiss", 8, 4);
        upd(32'h80, 0, 32'h300);
        look("noevict", 32'h40, 1, 0, 32'h44);  cnts("noevict", 9, 5);

        // Aliasing at index 0.
        upd(32'h60, 1, 32'h200);
        look("alias40", 32'h40, 0, 0, 32'h44);
        look("alias60", 32'h60, 1, 1, 32'h200); cnts("alias", 10, 5);

        // en=0 freezes everything.
        en = 0;
        upd(32'h60, 0, 32'h0);
        upd(32'h60, 0, 32'h0);
        look("en0", 32'h60, 1, 1, 32'h200);     cnts("en0", 10, 5);
        en = 1;

        // Randomized phase.
        pool[0] = 32'h40; pool[1] = 32'h60; pool[2] = 32'h80;
        pool[3] = 32'h44; pool[4] = 32'hFFFFFFFC; pool[5] = 32'h1004;
        for (int k = 0; k < 400; k++) begin
            PC         = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 5)];
            upd_valid  = $urandom_range(0, 3) != 0;
            upd_pc     = ($urandom_range(0, 7) == 0) ? $urandom : pool[$urandom_range(0, 5)];
            upd_taken  = $urandom_range(0, 1) == 1;
            upd_target = 32'h1000 + 32'($urandom_range(0, 2)) * 4;
            en         = $urandom_range(0, 7) != 0;
            @(posedge CLK); #2;
        end
        upd_valid = 0; en = 1;

        // Asynchronous reset mid-cycle after training.
        upd(32'h40, 1, 32'h100);
        #1; RST = 1; #1;
        look("midrst", 32'h40, 0, 0, 32'h44);   cnts("midrst", 0, 0);
        @(posedge CLK); #2; RST = 0;

        // Counter wrap: 65535 updates, then one more.
        upd_valid = 1; upd_pc = 32'h84; upd_taken = 0; upd_target = 0;
        repeat (65535) @(posedge CLK);
        #2;
        cnts("pre_wrap", 65535, 65535);
        @(posedge CLK); #2;
        upd_valid = 0;
        cnts("wrap", 0, 0);

        // PC+4 wraps.
        look("pcwrap", 32'hFFFFFFFC, 0, 0, 32'h0);

        @(posedge CLK); @(negedge CLK); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
